// File: rtl/z_core_m_pkg.sv
// Shared RV32M definitions: funct3 opcodes, FSM states and divider constants
// for the muldiv execute block.
package z_core_m_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   localparam logic [5:0]  DIV_ITERS = 6'd32;
   localparam logic [31:0] INT_MIN   = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

   // Two's-complement magnitude when en is set; |INT_MIN| stays INT_MIN (read as unsigned).
   function automatic logic [31:0] abs_cond(input logic [31:0] v, input logic en);
      return (en && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/z_core_muldiv_unit_if.sv
// Start/ready/done request bus between the core pipeline (master) and the
// M-extension unit (slave).
interface z_core_muldiv_unit_if;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        kill;
   logic        ready;
   logic        done;
   logic [31:0] result;

   modport master (output start, funct3, rs1, rs2, kill, input ready, done, result);
   modport slave  (input start, funct3, rs1, rs2, kill, output ready, done, result);
endinterface

// File: rtl/z_core_mult_unit.sv
// Combinational 32x32->64 multiplier; each operand is independently signed
// or unsigned so one array serves MUL/MULH/MULHSU/MULHU.
module z_core_mult_unit (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        a_signed_i,
   input  logic        b_signed_i,
   output logic [63:0] product_o
);
   logic signed [63:0] a_ext_s;
   logic signed [63:0] b_ext_s;

   assign a_ext_s   = {{32{a_signed_i & a_i[31]}}, a_i};
   assign b_ext_s   = {{32{b_signed_i & b_i[31]}}, b_i};
   assign product_o = a_ext_s * b_ext_s;
endmodule

// File: rtl/z_core_muldiv_unit.sv
// RV32M execute unit: single-pass multiply through z_core_mult_unit and a
// 1-bit/cycle restoring divider, with start/ready handshake and done pulse.
module z_core_muldiv_unit
   import z_core_m_pkg::*;
#(
   parameter int XLEN               = 32,
   parameter int DIV_BITS_PER_CYCLE = 1
) (
   input logic                 clk,
   input logic                 rstn,
   z_core_muldiv_unit_if.slave bus
);
   localparam logic [5:0] DIV_STEP = 6'(DIV_BITS_PER_CYCLE);

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
   logic [XLEN-1:0]   quot_q, quot_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [5:0]        cnt_q, cnt_d;
   logic              qneg_q, qneg_d, rneg_q, rneg_d;

   logic [63:0]       product_s;
   logic              accept_s, signed_div_s, div_zero_s, div_ovf_s;
   logic              a_signed_s, b_signed_s;
   logic [XLEN:0]     rem_shift_s, trial_s;
   logic [XLEN-1:0]   quot_next_s, rem_next_s, quot_fix_s, rem_fix_s;

   assign accept_s     = (state_q == S_IDLE) && bus.start && !bus.kill;
   assign signed_div_s = !bus.funct3[0];
   assign div_zero_s   = (bus.rs2 == {XLEN{1'b0}});
   assign div_ovf_s    = signed_div_s && (bus.rs1 == INT_MIN) && (bus.rs2 == ALL_ONES);

   assign a_signed_s = (op_q == F3_MULH) || (op_q == F3_MULHSU);
   assign b_signed_s = (op_q == F3_MULH);

   z_core_mult_unit u_mult (
      .a_i        (a_q),
      .b_i        (b_q),
      .a_signed_i (a_signed_s),
      .b_signed_i (b_signed_s),
      .product_o  (product_s)
   );

   // One restoring step: the trial difference is non-negative iff bit XLEN is clear.
   assign rem_shift_s = {rem_q, quot_q[XLEN-1]};
   assign trial_s     = rem_shift_s - {1'b0, dvs_q};
   assign quot_next_s = {quot_q[XLEN-2:0], !trial_s[XLEN]};
   assign rem_next_s  = trial_s[XLEN] ? rem_shift_s[XLEN-1:0] : trial_s[XLEN-1:0];
   assign quot_fix_s  = qneg_q ? (32'd0 - quot_next_s) : quot_next_s;
   assign rem_fix_s   = rneg_q ? (32'd0 - rem_next_s) : rem_next_s;

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         op_q     <= 3'd0;
         a_q      <= {XLEN{1'b0}};
         b_q      <= {XLEN{1'b0}};
         quot_q   <= {XLEN{1'b0}};
         rem_q    <= {XLEN{1'b0}};
         dvs_q    <= {XLEN{1'b0}};
         result_q <= {XLEN{1'b0}};
         cnt_q    <= 6'd0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
      end
   end

   // Next-state logic; kill returns any busy state to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!accept_s)                      state_d = S_IDLE;
            else if (!bus.funct3[2])            state_d = S_MUL;
            else if (div_zero_s || div_ovf_s)   state_d = S_DONE;
            else                                state_d = S_DIV;
         end
         S_MUL:   state_d = bus.kill ? S_IDLE : S_DONE;
         S_DIV: begin
            if (bus.kill)                 state_d = S_IDLE;
            else if (cnt_q == DIV_STEP)   state_d = S_DONE;
            else                          state_d = S_DIV;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: operand latch, divider iteration and result capture.
   always_comb begin
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      if (accept_s) begin
         op_d = bus.funct3;
         a_d  = bus.rs1;
         b_d  = bus.rs2;
         if (!bus.funct3[2]) begin
            cnt_d = 6'd0;
         end else if (div_zero_s) begin
            result_d = bus.funct3[1] ? bus.rs1 : ALL_ONES;
         end else if (div_ovf_s) begin
            result_d = bus.funct3[1] ? 32'd0 : INT_MIN;
         end else begin
            quot_d = abs_cond(bus.rs1, signed_div_s);
            dvs_d  = abs_cond(bus.rs2, signed_div_s);
            rem_d  = {XLEN{1'b0}};
            cnt_d  = DIV_ITERS;
            qneg_d = signed_div_s && (bus.rs1[31] ^ bus.rs2[31]);
            rneg_d = signed_div_s && bus.rs1[31];
         end
      end else if ((state_q == S_MUL) && !bus.kill) begin
         result_d = (op_q == F3_MUL) ? product_s[31:0] : product_s[63:32];
      end else if ((state_q == S_DIV) && !bus.kill) begin
         quot_d = quot_next_s;
         rem_d  = rem_next_s;
         cnt_d  = cnt_q - DIV_STEP;
         if (cnt_q == DIV_STEP) result_d = op_q[1] ? rem_fix_s : quot_fix_s;
         else                   result_d = result_q;
      end else begin
         result_d = result_q;
      end
   end

   // Handshake outputs decoded from the state register.
   always_comb begin
      bus.ready = (state_q == S_IDLE);
      bus.done  = (state_q == S_DONE);
   end

   assign bus.result = result_q;
endmodule

// File: tb/tb_z_core_muldiv_unit.sv
// Directed bench: an arithmetic model predicts result and the ready/done
// timeline, and a per-cycle monitor compares the DUT against it.
module tb_z_core_muldiv_unit;
   import z_core_m_pkg::*;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   z_core_muldiv_unit_if bus();

   z_core_muldiv_unit dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   bit          mon_en   = 1'b0;
   bit          m_active = 1'b0;
   bit          m_killed = 1'b0;
   bit          m_rst    = 1'b0;
   int          m_acc    = 0;
   int          m_end    = 0;
   logic [31:0] m_new    = 32'd0;
   logic [31:0] m_cur    = 32'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // RV32M semantics in plain integer arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      int          qa, qb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      qa = int'(a);
      qb = int'(b);
      case (f)
         3'b000: begin p = ua * ub; return p[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin p = ua * ub; return p[63:32]; end
         3'b100: begin
            if (b == 32'd0) return ALL_ONES;
            if (a == INT_MIN && b == ALL_ONES) return INT_MIN;
            return qa / qb;
         end
         3'b101: return (b == 32'd0) ? ALL_ONES : a / b;
         3'b110: begin
            if (b == 32'd0) return a;
            if (a == INT_MIN && b == ALL_ONES) return 32'd0;
            return qa % qb;
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (!f[2]) return 2;
      if (b == 32'd0) return 1;
      if (!f[0] && a == INT_MIN && b == ALL_ONES) return 1;
      return 33;
   endfunction

   // Per-cycle compare of ready/done/result against the model timeline.
   always @(negedge clk) begin
      if (mon_en) begin
         if (m_active && cyc == m_end) begin
            chk("ready_last_busy", {31'd0, bus.ready}, 32'd0);
            chk("done_at_end", {31'd0, bus.done}, {31'd0, !m_killed});
            chk("result_at_end", bus.result, m_killed ? m_cur : m_new);
            if (!m_killed) m_cur = m_new;
            if (m_rst) m_cur = 32'd0;
            m_active = 1'b0;
         end else begin
            chk("ready", {31'd0, bus.ready}, {31'd0, !(m_active && cyc > m_acc)});
            chk("done_idle", {31'd0, bus.done}, 32'd0);
            chk("result_hold", bus.result, m_cur);
         end
      end
   end

   task automatic wait_idle();
      int k;
      k = 0;
      while (m_active && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      if (m_active) begin
         chk("wait_idle_timeout", 32'd1, 32'd0);
         m_active = 1'b0;
      end
   endtask

   task automatic wait_until(input int target);
      int k;
      k = 0;
      while (cyc < target && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
   endtask

   task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string nm);
      chk({"model_", nm}, model(f, a, b), exp);
      bus.start = 1'b1;
      bus.funct3 = f;
      bus.rs1 = a;
      bus.rs2 = b;
      m_acc = cyc;
      m_end = cyc + latency(f, a, b);
      m_new = model(f, a, b);
      m_killed = 1'b0;
      m_rst = 1'b0;
      m_active = 1'b1;
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string nm);
      wait_idle();
      launch(f, a, b, exp, nm);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.funct3 = 3'($urandom_range(7, 0));
      bus.rs1 = $urandom;
      bus.rs2 = $urandom;
   endtask

   task automatic issue_kill(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp, input int off, input string nm);
      issue(f, a, b, exp, nm);
      wait_until(m_acc + off);
      bus.kill = 1'b1;
      m_end = cyc;
      m_killed = 1'b1;
      @(posedge clk); #1;
      bus.kill = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bus.start = 1'b0;
      bus.kill = 1'b0;
      bus.funct3 = 3'd0;
      bus.rs1 = 32'd0;
      bus.rs2 = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      chk("reset_ready", {31'd0, bus.ready}, 32'd1);
      chk("reset_done", {31'd0, bus.done}, 32'd0);
      chk("reset_result", bus.result, 32'd0);
      mon_en = 1'b1;
      @(posedge clk); #1;

      issue(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ff");
      issue(F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ff");
      issue(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_ff");
      issue(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff");
      issue(F3_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_min");
      issue(F3_MUL,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "mul_min");

      issue(F3_DIV, 32'hFFFF_FFF6, 32'd3,          32'hFFFF_FFFD, "div_m10_3");
      issue(F3_REM, 32'hFFFF_FFF6, 32'd3,          32'hFFFF_FFFF, "rem_m10_3");
      issue(F3_DIV, 32'd10,        32'hFFFF_FFFD,  32'hFFFF_FFFD, "div_10_m3");
      issue(F3_REM, 32'd10,        32'hFFFF_FFFD,  32'h0000_0001, "rem_10_m3");

      issue(F3_DIVU, 32'd7,        32'd0,          32'hFFFF_FFFF, "divu_by0");
      issue(F3_REMU, 32'd7,        32'd0,          32'h0000_0007, "remu_by0");
      issue(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
      issue(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");

      issue_kill(F3_DIVU, 32'd100, 32'd7, 32'd14, 10, "divu_killed");
      issue(F3_DIVU, 32'd100, 32'd7, 32'd14, "divu_100_7");
      issue(F3_REMU, 32'd100, 32'd7, 32'd2,  "remu_100_7");
      issue_kill(F3_MULHU, 32'd5, 32'd6, 32'd0, 1, "mulhu_killed");
      issue(F3_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, "divu_max_1");

      // start together with kill in IDLE must not be accepted
      wait_idle();
      bus.start = 1'b1;
      bus.kill = 1'b1;
      bus.funct3 = F3_MUL;
      bus.rs1 = 32'd9;
      bus.rs2 = 32'd9;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.kill = 1'b0;
      @(negedge clk);
      chk("kill_beats_start", {31'd0, bus.ready}, 32'd1);
      @(posedge clk); #1;

      // reset in the middle of a divide
      issue(F3_DIV, 32'hFFFF_FFF6, 32'd3, 32'hFFFF_FFFD, "div_reset");
      wait_until(m_acc + 5);
      rstn = 1'b0;
      m_end = cyc;
      m_killed = 1'b1;
      m_rst = 1'b1;
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      chk("midop_reset_ready", {31'd0, bus.ready}, 32'd1);
      chk("midop_reset_result", bus.result, 32'd0);
      @(posedge clk); #1;

      // start held high across DONE: second op only from the following IDLE cycle
      wait_idle();
      launch(F3_MUL, 32'd3, 32'd5, 32'd15, "mul_hold1");
      @(posedge clk); #1;
      bus.rs1 = 32'd6;
      bus.rs2 = 32'd7;
      wait_until(m_end + 1);
      if (m_active) chk("hold_model_busy", 32'd1, 32'd0);
      launch(F3_MUL, 32'd6, 32'd7, 32'd42, "mul_hold2");
      @(posedge clk); #1;
      bus.start = 1'b0;

      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
